// File: rtl/fifo_write_arbiter.sv
// ============================================================================
// Module   : fifo_write_arbiter
// Brief    : Round-robin arbiter sharing one FIFO write port among NUM_REQ
//            producers, with bursts of up to MAX_BURST beats per grant.
//            Optional macro FIFO_ARB_THROTTLE_EN restricts IDLE arbitration
//            to requester 0 while fifo_half_full is set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic                          fifo_half_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int IDW   = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] c_burst_max = CNT_W'(MAX_BURST);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t                r_state;
  logic [IDW-1:0]        r_grant_id;
  logic [IDW-1:0]        r_last_grant;
  logic [CNT_W-1:0]      r_beat_cnt;

  logic [DATA_WIDTH-1:0] w_slice [NUM_REQ];
  logic [NUM_REQ-1:0]    w_elig;
  logic [IDW-1:0]        w_idx;
  logic [IDW-1:0]        w_pick;
  logic                  w_any;
  logic                  w_accept;
  logic                  w_last_beat;

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
      assign w_slice[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

`ifdef FIFO_ARB_THROTTLE_EN
  // Near-full FIFO: only the high-priority channel may start a new burst.
  assign w_elig = fifo_half_full ? {{(NUM_REQ-1){1'b0}}, req_valid[0]} : req_valid;
`else
  logic w_unused_half_full;
  assign w_unused_half_full = fifo_half_full;
  assign w_elig             = req_valid;
`endif

  // Scan downward so the candidate nearest last_grant+1 is assigned last.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = IDW'((int'(r_last_grant) + k) % NUM_REQ);
      if (w_elig[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  assign w_accept    = (r_state == ST_GRANT) && req_valid[r_grant_id] && !fifo_full;
  assign w_last_beat = req_last[r_grant_id] || ((r_beat_cnt + CNT_W'(1)) == c_burst_max);

  always_comb begin
    req_ready = '0;
    if (r_state == ST_GRANT) begin
      req_ready[r_grant_id] = !fifo_full;
    end
  end

  assign fifo_w_en    = w_accept;
  assign fifo_data_in = w_accept ? w_slice[r_grant_id] : '0;
  assign grant_id     = r_grant_id;
  assign busy         = (r_state == ST_GRANT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_grant_id   <= '0;
      r_last_grant <= IDW'(NUM_REQ - 1);
      r_beat_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_beat_cnt <= '0;
          if (w_any) begin
            r_grant_id <= w_pick;
            r_state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_accept) begin
            if (w_last_beat) begin
              r_state      <= ST_IDLE;
              r_last_grant <= r_grant_id;
              r_beat_cnt   <= '0;
            end else begin
              r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
// ============================================================================
// Module   : tb_fifo_write_arbiter
// Brief    : Self-checking bench for fifo_write_arbiter: behavioural model,
//            per-cycle compare, directed scenarios and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_write_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_last = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]   req_ready;
  logic            fifo_full = 1'b0;
  logic            fifo_half_full = 1'b0;
  logic            fifo_w_en;
  logic [DW-1:0]   fifo_data_in;
  logic [1:0]      grant_id;
  logic            busy;

  int n_vec = 0;
  int n_err = 0;

  fifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_half_full(fifo_half_full), .fifo_w_en(fifo_w_en),
    .fifo_data_in(fifo_data_in), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic       m_busy = 1'b0;
  logic [1:0] m_g = '0;
  logic [1:0] m_last = 2'd3;
  int         m_cnt = 0;
  logic [NR-1:0] m_elig;
  int         m_pick;

  function automatic int rr_pick(input logic [NR-1:0] elig, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (elig[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

`ifdef FIFO_ARB_THROTTLE_EN
  assign m_elig = fifo_half_full ? (req_valid & 4'b0001) : req_valid;
`else
  assign m_elig = req_valid;
`endif
  assign m_pick = rr_pick(m_elig, int'(m_last));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_g    <= '0;
      m_last <= 2'(NR - 1);
      m_cnt  <= 0;
    end else if (!m_busy) begin
      if (m_pick >= 0) begin
        m_busy <= 1'b1;
        m_g    <= 2'(m_pick);
        m_cnt  <= 0;
      end
    end else if (req_valid[m_g] && !fifo_full) begin
      if (req_last[m_g] || (m_cnt + 1 >= MB)) begin
        m_busy <= 1'b0;
        m_last <= m_g;
        m_cnt  <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  logic          e_wen;
  logic [NR-1:0] e_ready;
  logic [DW-1:0] e_data;
  assign e_wen   = m_busy && req_valid[m_g] && !fifo_full;
  assign e_ready = (m_busy && !fifo_full) ? (4'b0001 << m_g) : 4'b0000;
  assign e_data  = e_wen ? req_data[m_g*DW +: DW] : 8'h00;

  // ---------------- compare process + logs ----------------
  typedef struct packed {logic [1:0] id; logic [7:0] d;} wr_t;
  wr_t        wlog[$];
  logic [1:0] glog[$];
  logic       prev_busy = 1'b0;

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_busy));
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    chk("fifo_w_en", 32'(fifo_w_en), 32'(e_wen));
    chk("fifo_data_in", 32'(fifo_data_in), 32'(e_data));
    if (m_busy || !rst_n) chk("grant_id", 32'(grant_id), 32'(m_g));
    if (fifo_w_en) wlog.push_back('{grant_id, fifo_data_in});
    if (busy && !prev_busy) glog.push_back(grant_id);
    prev_busy <= busy;
  end

  // ---------------- producers ----------------
  int         rem [NR];
  int         mode [NR];   // 0: never last, 1: last on final beat, 2: last every beat
  logic       hold [NR];
  logic [7:0] nd [NR];
  logic       rnd_data = 1'b0;

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = (rem[i] > 0) && !hold[i];
      req_last[i]           = (mode[i] == 2) || (mode[i] == 1 && rem[i] == 1);
      req_data[i*DW +: DW]  = nd[i];
    end
  endtask

  task automatic step();
    logic [NR-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        rem[i]--;
        nd[i] = rnd_data ? 8'($urandom) : nd[i] + 8'd1;
      end
    end
    drive();
  endtask

  task automatic clear_prod();
    for (int i = 0; i < NR; i++) begin
      rem[i] = 0; mode[i] = 1; hold[i] = 1'b0; nd[i] = '0;
    end
    drive();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    wlog.delete();
    glog.delete();
  endtask

  task automatic wait_writes(input int n, input int budget);
    int c = 0;
    while (wlog.size() < n && c < budget) begin
      step();
      c++;
    end
    chk("wait_writes_timeout", 32'(wlog.size() >= n), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    clear_prod();
    #1 rst_n = 1'b0;

    // T1: single requester, single beat after reset release
    rem[0] = 1; mode[0] = 1; nd[0] = 8'hA5;
    drive();
    step();
    step();
    rst_n = 1'b1;
    wlog.delete(); glog.delete();
    step();
    #1;
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_grant", 32'(grant_id), 32'd0);
    chk("t1_wen", 32'(fifo_w_en), 32'd1);
    chk("t1_data", 32'(fifo_data_in), 32'hA5);
    step();
    #1;
    chk("t1_busy_fall", 32'(busy), 32'd0);
    chk("t1_nwrites", 32'(wlog.size()), 32'd1);

    // T2: all requesting, last on every beat -> 0,1,2,3,0
    for (int i = 0; i < NR; i++) begin
      rem[i] = 100; mode[i] = 2; nd[i] = 8'(i * 16);
    end
    drive();
    pulse_reset();
    for (int s = 0; s < 10; s++) step();
    clear_prod();
    step();
    chk("t2_nwrites", 32'(wlog.size()), 32'd5);
    for (int k = 0; k < 5 && k < wlog.size(); k++) begin
      chk("t2_wid", 32'(wlog[k].id), 32'(k % 4));
      chk("t2_wdata", 32'(wlog[k].d), 32'((k % 4) * 16 + k / 4));
      chk("t2_grant", 32'(glog[k]), 32'(k % 4));
    end

    // T3: requester 2 streams 10 beats; bursts capped, others served between
    begin : t3
      int ids [12];
      int dat [12];
      ids = '{2, 2, 2, 2, 3, 0, 2, 2, 2, 2, 2, 2};
      dat = '{'h20, 'h21, 'h22, 'h23, 'h30, 'h40, 'h24, 'h25, 'h26, 'h27, 'h28, 'h29};
      pulse_reset();
      rem[2] = 10; mode[2] = 1; nd[2] = 8'h20;
      drive();
      step();
      rem[3] = 1; mode[3] = 1; nd[3] = 8'h30;
      rem[0] = 1; mode[0] = 1; nd[0] = 8'h40;
      drive();
      wait_writes(12, 80);
      for (int s = 0; s < 4; s++) step();
      chk("t3_nwrites", 32'(wlog.size()), 32'd12);
      for (int k = 0; k < 12 && k < wlog.size(); k++) begin
        chk("t3_wid", 32'(wlog[k].id), 32'(ids[k]));
        chk("t3_wdata", 32'(wlog[k].d), 32'(dat[k]));
      end
      chk("t3_ngrants", 32'(glog.size()), 32'd5);
    end

    // T4: FIFO full for 3 cycles in the middle of a burst
    pulse_reset();
    rem[1] = 4; mode[1] = 1; nd[1] = 8'h50;
    drive();
    wait_writes(2, 20);
    fifo_full = 1'b1;
    #1;
    chk("t4_ready_full", 32'(req_ready), 32'd0);
    chk("t4_wen_full", 32'(fifo_w_en), 32'd0);
    step(); step(); step();
    chk("t4_nwrites_frozen", 32'(wlog.size()), 32'd2);
    fifo_full = 1'b0;
    wait_writes(4, 20);
    for (int s = 0; s < 3; s++) step();
    chk("t4_nwrites", 32'(wlog.size()), 32'd4);
    for (int k = 0; k < 4 && k < wlog.size(); k++) begin
      chk("t4_wdata", 32'(wlog[k].d), 32'(8'h50 + k));
    end

    // T5: reset mid-burst, then requester 0 wins first
    pulse_reset();
    rem[3] = 4; mode[3] = 1; nd[3] = 8'h60;
    drive();
    wait_writes(2, 20);
    rst_n = 1'b0;
    rem[0] = 1; mode[0] = 1; nd[0] = 8'h70;
    drive();
    #1;
    chk("t5_busy_rst", 32'(busy), 32'd0);
    chk("t5_wen_rst", 32'(fifo_w_en), 32'd0);
    chk("t5_ready_rst", 32'(req_ready), 32'd0);
    chk("t5_data_rst", 32'(fifo_data_in), 32'd0);
    chk("t5_grant_rst", 32'(grant_id), 32'd0);
    step(); step();
    rst_n = 1'b1;
    wlog.delete(); glog.delete();
    for (int s = 0; s < 12; s++) step();
    chk("t5_first_grant", 32'(glog[0]), 32'd0);
    chk("t5_second_grant", 32'(glog[1]), 32'd3);

    // T6: half-full throttle behaviour
    clear_prod();
    pulse_reset();
    fifo_half_full = 1'b1;
    rem[1] = 1; rem[2] = 1;
    drive();
    step(); step(); step();
`ifdef FIFO_ARB_THROTTLE_EN
    chk("t6_no_grant", 32'(glog.size()), 32'd0);
    rem[0] = 1;
    drive();
    step(); step();
    chk("t6_grant0", 32'(glog[0]), 32'd0);
`else
    chk("t6_grant1", 32'(glog[0]), 32'd1);
`endif
    fifo_half_full = 1'b0;
    for (int s = 0; s < 12; s++) step();

    // Random traffic against the model
    clear_prod();
    pulse_reset();
    rnd_data = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NR; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 7) == 0) begin
          rem[i]  = int'($urandom_range(1, 7));
          mode[i] = int'($urandom_range(0, 2));
          nd[i]   = 8'($urandom);
        end
        hold[i] = ($urandom_range(0, 9) == 0);
      end
      fifo_full      = ($urandom_range(0, 3) == 0);
      fifo_half_full = 1'($urandom_range(0, 1));
      rst_n          = (cyc % 1000 != 999);
      drive();
      step();
    end
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin arbiter that shares the single write port of a synchronous_fifo instance among NUM_REQ producers.
- Grants one producer at a time for a burst of up to MAX_BURST beats.
- Drives the FIFO's w_en/data_in from the granted producer; backpressures producers from the FIFO's full flag.
- Sits directly in front of the FIFO write port; the FIFO read side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, beat width; must match the FIFO DATA_WIDTH.
- MAX_BURST, 4, maximum beats per grant (1..255).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester beat valid.
- req_last  input  NUM_REQ  per-requester end-of-burst marker, qualified by req_valid.
- req_data  input  NUM_REQ*DATA_WIDTH  packed beats; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  per-requester beat accept.
- fifo_full  input  1  FIFO full flag.
- fifo_half_full  input  1  FIFO half_full flag.
- fifo_w_en  output  1  FIFO write enable.
- fifo_data_in  output  DATA_WIDTH  FIFO write data.
- grant_id  output  $clog2(NUM_REQ)  index of the current grant holder; valid while busy=1.
- busy  output  1  1 while in GRANT state.

Behaviour:
- Async reset (rst_n=0), effective immediately:
  - state=IDLE; busy=0; grant_id=0; req_ready=0; fifo_w_en=0; fifo_data_in=0 (combinational zero when not transferring).
  - last_grant=NUM_REQ-1, so requester 0 wins first; beat_cnt=0.
  - Reset mid-burst abandons the burst; no partial-beat write occurs.
- FSM IDLE:
  - If any req_valid bit is set, select the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Register it into grant_id; go to GRANT next cycle. Arbitration latency is 1 cycle.
  - beat_cnt cleared.
  - No req_ready is asserted in IDLE.
- FSM GRANT, with g = grant_id:
  - req_ready[g] = !fifo_full (combinational). All other req_ready bits are 0.
  - A beat is accepted when req_valid[g] & req_ready[g]. In that same cycle:
    - fifo_w_en=1;
    - fifo_data_in=req_data slice g;
    - beat_cnt increments.
  - When no beat is accepted, fifo_w_en=0 and fifo_data_in=0.
  - Exit to IDLE on the clock edge after an accepted beat with req_last[g]=1, or when beat_cnt reaches MAX_BURST.
  - On exit, last_grant<=g.
  - No preemption: if req_valid[g] deasserts mid-burst, the grant is held with no writes until the burst ends.
- Full boundary: while fifo_full=1, no write is issued, the grant is held, and beat_cnt is frozen. fifo_w_en is never asserted while fifo_full=1.
- Simultaneous requests: strict round-robin. A requester that just finished cannot win again while any other requester has req_valid set.
- Single requester: re-granted after the 1-cycle IDLE gap.
- Width rules:
  - beat_cnt is $clog2(MAX_BURST+1) bits and never wraps.
  - Round-robin index arithmetic is modulo NUM_REQ, including non-power-of-2 NUM_REQ.

Optional Feature:
- FIFO_ARB_THROTTLE_EN defined:
  - While fifo_half_full=1, IDLE arbitration considers only requester 0 (high-priority channel); other requests wait.
  - A burst already in GRANT is unaffected.
  - Round-robin pointer updates as normal when requester 0 is granted.
- Not defined: fifo_half_full is ignored (port remains, unused) and arbitration is pure round-robin.

Test Plan:
- Reset release with req_valid=4'b0001, req_last=1, data 8'hA5 -> grant_id=0 one cycle later; single fifo_w_en pulse with fifo_data_in=8'hA5; busy falls the next cycle.
- req_valid=4'b1111 held, req_last=1 every beat -> grant order 0,1,2,3,0; exactly one write per grant, with an IDLE cycle between grants.
- Requester 2 streams 10 beats with req_last=0, MAX_BURST=4 -> 4 writes, then forced IDLE; other requesters are served before requester 2 resumes.
- fifo_full=1 for 3 cycles mid-burst -> req_ready=0 and fifo_w_en=0 during those cycles; burst resumes with the next data word, and no beat is lost or duplicated.
- rst_n pulsed low mid-burst (beat 2 of 4) -> outputs go to 0 immediately; after release, requester 0 is granted first.
- With FIFO_ARB_THROTTLE_EN, fifo_half_full=1, req_valid=4'b0110 -> no grant; set req_valid[0]=1 -> grant_id=0. Without the macro -> grant_id=1.
